// File: rtl/var_delay_fifo.sv
// rtl/var_delay_fifo.sv - runtime-programmable delay line on inferred block RAM
//
// Every clock {validIn, dataIn} is written into a MAX_DELAY-deep circular
// buffer and re-emitted exactly D clocks later (D in 1..MAX_DELAY, loadable
// at runtime). Outputs are forced to zero until a full window of D samples
// has been written since the last reset or load, so stale RAM is never seen.
//
// Ports:
//   clock      in   1      sole clock, rising edge
//   reset      in   1      synchronous active-high reset
//   loadDelay  in   1      strobe: latch sanitised delayIn as the new D
//   delayIn    in   DW     requested delay (0 -> 1, >MAX_DELAY -> MAX_DELAY)
//   validIn    in   1      sample qualifier, stored with the data
//   dataIn     in   WIDTH  sample data
//   validOut   out  1      delayed validIn, gated by primed
//   dataOut    out  WIDTH  delayed dataIn, zero while not primed
//   delayOut   out  DW     currently active delay
//   primed     out  1      a full window of D samples has been written
module var_delay_fifo #(
  parameter int WIDTH      = 32,
  parameter int MAX_DELAY  = 256,
  parameter int DELAY_INIT = 3,
  localparam int DW        = $clog2(MAX_DELAY) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             loadDelay,
  input  logic [DW-1:0]    delayIn,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             validOut,
  output logic [WIDTH-1:0] dataOut,
  output logic [DW-1:0]    delayOut,
  output logic             primed
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam logic [DW-1:0] MAX_D  = DW'(MAX_DELAY);
  localparam logic [DW-1:0] INIT_D = DW'(DELAY_INIT);

  logic [WIDTH:0]  mem [MAX_DELAY];
  logic [WIDTH:0]  rd_q;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   delay_q;
  logic [DW-1:0]   delay_sane;
  logic [DW-1:0]   fill_cnt;
  logic [DW-1:0]   fill_next;
  logic            primed_q;
  logic            restart;

  always_comb begin
    delay_sane = delayIn;
    if (delayIn == '0) begin
      delay_sane = DW'(1);
    end else if (delayIn > MAX_D) begin
      delay_sane = MAX_D;
    end
  end

  assign restart = reset | loadDelay;

  // Window length counter: zero on the restart edge, so it reaches D on the
  // same edge the restart-edge sample is read back out.
  always_comb begin
    fill_next = fill_cnt;
    if (restart) begin
      fill_next = '0;
    end else if (fill_cnt != delay_q) begin
      fill_next = fill_cnt + DW'(1);
    end
  end

  // Entry written at wr_ptr is read back when wr_ptr has advanced by D.
  // For D = MAX_DELAY the low AW bits of D are zero, so rd_addr == wr_addr
  // and the nonblocking RAM read returns the old entry (read-before-write).
  assign rd_addr = wr_ptr - delay_q[AW-1:0];

  // The reset edge starts a window just like a load edge. Since wr_ptr
  // restarts at 0, the reset-edge sample belongs one slot behind it.
  assign wr_addr = reset ? {AW{1'b1}} : wr_ptr;

  always_ff @(posedge clock) begin
    mem[wr_addr] <= {validIn, dataIn};
    rd_q         <= mem[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      delay_q  <= INIT_D;
      fill_cnt <= '0;
      primed_q <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(1);
      if (loadDelay) begin
        delay_q <= delay_sane;
      end
      fill_cnt <= fill_next;
      primed_q <= (fill_next == delay_q) && !loadDelay;
    end
  end

  // Gating uses only registered signals, so there is no input-to-output path.
  assign validOut = primed_q & rd_q[WIDTH];
  assign dataOut  = primed_q ? rd_q[WIDTH-1:0] : '0;
  assign delayOut = delay_q;
  assign primed   = primed_q;

endmodule

// File: tb/tb_var_delay_fifo.sv
// tb/tb_var_delay_fifo.sv - scoreboard bench for var_delay_fifo
module tb_var_delay_fifo;

  localparam int WIDTH = 32;
  localparam int MAXD  = 256;
  localparam int DW    = 9;
  localparam int DINIT = 3;

  logic             clock;
  logic             reset;
  logic             loadDelay;
  logic [DW-1:0]    delayIn;
  logic             validIn;
  logic [WIDTH-1:0] dataIn;
  logic             validOut;
  logic [WIDTH-1:0] dataOut;
  logic [DW-1:0]    delayOut;
  logic             primed;

  var_delay_fifo #(.WIDTH(WIDTH), .MAX_DELAY(MAXD), .DELAY_INIT(DINIT)) dut (
    .clock(clock), .reset(reset), .loadDelay(loadDelay), .delayIn(delayIn),
    .validIn(validIn), .dataIn(dataIn), .validOut(validOut), .dataOut(dataOut),
    .delayOut(delayOut), .primed(primed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             p;
    logic [DW-1:0]    dl;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH:0]   hist[$];
  int               edge_no = 0;
  int               win_start = 0;
  int               cur_d = DINIT;
  int               n_checks = 0;
  int               n_fail = 0;
  int               counter = 0;

  function automatic int sanitise(input int x);
    if (x == 0) return 1;
    if (x > MAXD) return MAXD;
    return x;
  endfunction

  // Reference model: a window starts on any reset/load edge (that edge's
  // sample is its first member); output after edge t is the sample of edge
  // t-D once at least D edges have passed since the window start.
  task automatic step(input logic rst, input logic ld, input int dly,
                      input logic v, input logic [WIDTH-1:0] d);
    exp_t e;
    int   k;
    reset     = rst;
    loadDelay = ld;
    delayIn   = DW'(dly);
    validIn   = v;
    dataIn    = d;
    @(posedge clock);
    hist.push_back({v, d});
    if (rst) begin
      win_start = edge_no;
      cur_d     = DINIT;
    end else if (ld) begin
      win_start = edge_no;
      cur_d     = sanitise(dly);
    end
    k = edge_no - win_start;
    if (k >= cur_d) begin
      e.v = hist[edge_no - cur_d][WIDTH];
      e.d = hist[edge_no - cur_d][WIDTH-1:0];
      e.p = 1'b1;
    end else begin
      e.v = 1'b0;
      e.d = '0;
      e.p = 1'b0;
    end
    e.dl = DW'(cur_d);
    exp_q.push_back(e);
    edge_no++;
    #1;
  endtask

  task automatic stream(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      counter++;
      if (rnd) step(1'b0, 1'b0, 0, 1'($urandom_range(0, 1)), $urandom());
      else     step(1'b0, 1'b0, 0, 1'(counter & 1), WIDTH'(counter));
    end
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", name, n_checks / 4, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("validOut", WIDTH'(validOut), WIDTH'(e.v));
        check("dataOut",  dataOut,          e.d);
        check("primed",   WIDTH'(primed),   WIDTH'(e.p));
        check("delayOut", WIDTH'(delayOut), WIDTH'(e.dl));
      end
    end
  end

  initial begin
    reset = 1'b1; loadDelay = 1'b0; delayIn = '0; validIn = 1'b0; dataIn = '0;
    // Reset then incrementing stream at D=3
    step(1'b1, 1'b0, 0, 1'b0, '0);
    step(1'b1, 1'b0, 0, 1'b1, 32'd1);
    for (int i = 2; i <= 20; i++) step(1'b0, 1'b0, 0, 1'b1, WIDTH'(i));
    // D=1, alternating valid, through pointer wrap
    counter = 100;
    step(1'b0, 1'b1, 1, 1'b1, 32'h100);
    stream(800, 1'b0);
    // D=MAX_DELAY over more than three wraps
    step(1'b0, 1'b1, 256, 1'b0, 32'h200);
    stream(800, 1'b0);
    // Clamping: 0 -> 1, 300 -> 256
    step(1'b0, 1'b1, 0, 1'b1, 32'h300);
    stream(20, 1'b1);
    step(1'b0, 1'b1, 300, 1'b1, 32'h301);
    stream(300, 1'b1);
    // Mid-stream load 10 -> 4
    step(1'b0, 1'b1, 10, 1'b1, 32'h400);
    stream(30, 1'b0);
    step(1'b0, 1'b1, 4, 1'b1, 32'h401);
    stream(20, 1'b0);
    // Back-to-back loads, last wins
    step(1'b0, 1'b1, 5, 1'b1, 32'h500);
    step(1'b0, 1'b1, 7, 1'b1, 32'h501);
    stream(20, 1'b1);
    // Reset mid-stream with loadDelay high: reset wins
    step(1'b1, 1'b1, 50, 1'b1, 32'h600);
    stream(20, 1'b1);
    // Randomised loads and resets
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)      step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 511)), 1'b1, $urandom());
      else if (r < 5) step(1'b0, 1'b1, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), $urandom());
      else            step(1'b0, 1'b0, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), $urandom());
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/var_delay_fifo.md
# var_delay_fifo

Runtime-programmable delay line for the capture path: each clock, `{validIn, dataIn}` is written into a circular buffer and re-emitted exactly `D` clocks later. `D` ranges from 1 to `MAX_DELAY` and is loaded at runtime, replacing the fixed 1–16 shift-register delay. Storage is inferred block RAM with registered outputs, so depth costs RAM rather than LUTs. The block sits between the trigger/sampler stages, where the trigger pipeline latency is now configurable.

## Interface
- `WIDTH`, 32, data bits per sample (valid is carried separately).
- `MAX_DELAY`, 256, maximum delay in clocks; must be a power of two, at least 2.
- `DELAY_INIT`, 3, delay after reset; must be in 1..`MAX_DELAY`.
- `DW` (localparam), clog2(`MAX_DELAY`)+1, width of delay values.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `loadDelay`  in  1  strobe; latch `delayIn` as the new delay this edge.
- `delayIn`  in  DW  requested delay in clocks.
- `validIn`  in  1  sample-valid qualifier, stored alongside data.
- `dataIn`  in  WIDTH  sample data.
- `validOut`  out  1  delayed `validIn`, gated by `primed`.
- `dataOut`  out  WIDTH  delayed `dataIn`; 0 while not primed.
- `delayOut`  out  DW  currently active delay.
- `primed`  out  1  high once `D` clocks have been written since the last reset or load.

## Operation
- Write side: a write occurs every clock, regardless of `validIn`. `wrPtr` (clog2(`MAX_DELAY`) bits) increments by 1 each clock and wraps modulo `MAX_DELAY`.
- Read side: `rdPtr` is derived from `wrPtr` and `D`, so that the entry written at edge t drives the outputs after edge t+D. Pointer arithmetic is modulo `MAX_DELAY`. With `D = MAX_DELAY`, the entry is read on the same edge it is overwritten; read-before-write ordering is required.
- Delay sanitising on load:
  - `delayIn = 0` loads D=1.
  - `delayIn > MAX_DELAY` loads D=`MAX_DELAY`.
  - The sanitised value appears on `delayOut` the cycle after the load edge.
- Fill counter `fillCnt` (DW bits):
  - Cleared by `reset` or `loadDelay`.
  - Increments each clock, saturating at D.
  - `primed` = (`fillCnt` == D), registered.
- Output gating: while `primed` = 0, `validOut` = 0 and `dataOut` = 0. No stale RAM content is ever emitted.
- Load coincident with a sample: the sample written on the `loadDelay` edge is the first sample of the new window. It emerges D_new clocks later, with `primed` rising on that same edge. Samples written before the load are never emitted.
- Reset:
  - `wrPtr` = 0, `fillCnt` = 0, D = `DELAY_INIT`.
  - Outputs: `validOut` = 0, `dataOut` = 0, `primed` = 0, `delayOut` = `DELAY_INIT`.
  - RAM is not cleared.
- Reset together with `loadDelay`: reset wins and D = `DELAY_INIT`.
- Mid-stream reset: outputs are 0 on the next cycle, then the block refills from the post-reset samples only.

## Timing
- Latency is exactly D clocks: edge-to-edge from input capture to output update, for every D in 1..`MAX_DELAY`, including D=1 (equivalent to a single register stage).
- Throughput is one sample per clock, with no stalls and no backpressure.
- `primed` rises on the same edge as the first valid output after fill. It then stays high until the next reset or load.
- `loadDelay` takes effect on the edge it is sampled; `delayOut` and `primed` = 0 are visible the following cycle.
- Back-to-back `loadDelay` strobes: each strobe restarts the fill, and the last one wins.
- Registered RAM output plus output gating must close timing at sampler clock rate, with no combinational path from input to output.

## Test plan
- **Reset then stream, D=3:** after reset, drive `dataIn` = 1, 2, 3…, `validIn` = 1.
  - `validOut`/`dataOut` are 0 for 3 clocks.
  - Then `dataOut` = 1, 2, 3… with `validOut` = 1.
  - `primed` rises with `dataOut` = 1.
- **Load D=1 and D=`MAX_DELAY` (256):** stream an incrementing pattern with an alternating `validIn`.
  - Output equals input shifted by exactly 1 and 256 clocks respectively, with `validIn` preserved.
  - Run at least 3×256 clocks to cover pointer wrap.
- **Clamping:** load `delayIn` = 0, then 300 (DW=9).
  - `delayOut` = 1, then 256.
  - Latency measured at 1 and 256.
- **Mid-stream load:** at D=10, load D=4 while streaming.
  - Outputs are 0 for 4 clocks.
  - The first emitted sample is the one on the load edge; no pre-load samples appear.
- **Reset mid-stream with `loadDelay` high:**
  - `delayOut` = 3 and outputs are 0 the next cycle.
  - After 3 clocks, output resumes with post-reset samples only.
